// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks an active-low row strobe, debounces whole-keypad
// snapshots and shifts each accepted key into a 16-bit hex entry register.
module keypad_scan #(
   parameter int SCAN_DIV       = 25000,
   parameter int DEBOUNCE_SCANS = 8
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic [3:0]  col_in,
   input  logic        entry_clear,
   output logic [3:0]  row_out,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic        key_held,
   output logic [15:0] entry_value
);

   localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESS,
      ST_HELD,
      ST_RELEASE
   } state_t;

   logic [3:0]       col_meta_q, col_sync_q;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       row_q, row_d;
   logic [15:0]      snap_q, snap_d;
   logic [15:0]      prev_q, prev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   state_t           state_q, state_d;
   logic             key_valid_q, key_valid_d;
   logic [3:0]       key_code_q, key_code_d;
   logic             key_held_q, key_held_d;
   logic [15:0]      entry_q, entry_d;

   logic             sample;
   logic             scan_end;
   logic [15:0]      scan_word;
   logic             is_none;
   logic             is_single;
   logic [3:0]       key_idx;

   assign sample   = (div_q == DIV_LAST);
   assign scan_end = sample && (row_q == 2'd3);

   // scan_word is the snapshot with the row being sampled right now already folded in,
   // so at scan end it holds the complete 16-bit picture of the keypad.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_slot
         logic hit;
         assign hit = sample && (row_q == 2'(gi));
         assign scan_word[4*gi +: 4] = hit ? ~col_sync_q : snap_q[4*gi +: 4];
      end
   endgenerate

   assign snap_d    = scan_word;
   assign is_none   = (scan_word == 16'h0000);
   assign is_single = !is_none && ((scan_word & (scan_word - 16'h0001)) == 16'h0000);

   always_comb begin
      key_idx = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (scan_word[i]) begin
            key_idx = 4'(i);
         end
      end
   end

   always_comb begin
      div_d = div_q;
      row_d = row_q;
      if (sample) begin
         div_d = '0;
         row_d = row_q + 2'd1;
      end else begin
         div_d = div_q + 1'b1;
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      prev_d = prev_q;
      if (scan_end) begin
         prev_d = scan_word;
         if (scan_word == prev_q) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
         end else begin
            cnt_d = CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;
      key_held_d  = key_held_q;
      if (scan_end) begin
         case (state_q)
            ST_IDLE: begin
               if (is_single) begin
                  state_d = ST_PRESS;
               end
            end
            ST_PRESS: begin
               if (!is_single) begin
                  state_d = ST_IDLE;
               end else if (cnt_d == CNT_MAX) begin
                  state_d     = ST_HELD;
                  key_valid_d = 1'b1;
                  key_code_d  = key_idx;
                  key_held_d  = 1'b1;
               end
            end
            ST_HELD: begin
               // Rollover and extra keys while held are deliberately ignored.
               if (is_none) begin
                  state_d = ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               if (!is_none) begin
                  state_d = ST_HELD;
               end else if (cnt_d == CNT_MAX) begin
                  state_d    = ST_IDLE;
                  key_held_d = 1'b0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // A clear on the same edge as an accepted key drops that digit.
   always_comb begin
      entry_d = entry_q;
      if (entry_clear) begin
         entry_d = 16'h0000;
      end else if (key_valid_d) begin
         entry_d = {entry_q[11:0], key_code_d};
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         col_meta_q  <= 4'hF;
         col_sync_q  <= 4'hF;
         div_q       <= '0;
         row_q       <= 2'd0;
         snap_q      <= 16'h0000;
         prev_q      <= 16'h0000;
         cnt_q       <= '0;
         state_q     <= ST_IDLE;
         key_valid_q <= 1'b0;
         key_code_q  <= 4'h0;
         key_held_q  <= 1'b0;
         entry_q     <= 16'h0000;
      end else begin
         col_meta_q  <= col_in;
         col_sync_q  <= col_meta_q;
         div_q       <= div_d;
         row_q       <= row_d;
         snap_q      <= snap_d;
         prev_q      <= prev_d;
         cnt_q       <= cnt_d;
         state_q     <= state_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         key_held_q  <= key_held_d;
         entry_q     <= entry_d;
      end
   end

   assign row_out     = ~(4'b0001 << row_q);
   assign key_valid   = key_valid_q;
   assign key_code    = key_code_q;
   assign key_held    = key_held_q;
   assign entry_value = entry_q;

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans a 4x4 matrix keypad and turns debounced key presses into hex digits for the board-level top. It is the input-side counterpart of the multiplexed 7-segment display scanner: it drives rows one at a time and reads columns. Each accepted key shifts one hex digit into a 16-bit entry register. That register feeds the same 16-bit data path the display selector shows.

## Interface
- SCAN_DIV, default 25000: CLK cycles per row step. Must be >= 4.
- DEBOUNCE_SCANS, default 8: consecutive identical full scans required to accept a press or a release. Must be >= 2.
- CLK  in  1  board clock; every register updates on its rising edge.
- Reset  in  1  reset, synchronous and active-high.
- col_in  in  4  keypad columns, active-low (pulled up); asynchronous to CLK.
- entry_clear  in  1  synchronous clear of entry_value.
- row_out  out  4  row drive, active-low, exactly one bit low.
- key_valid  out  1  one-cycle pulse when a press is accepted.
- key_code  out  4  code of the last accepted key: 4*row + col.
- key_held  out  1  high while an accepted key has not yet been released.
- entry_value  out  16  shift register of entered hex digits, newest in [3:0].

## Operation
- col_in passes through a 2-flop synchronizer before any use.
- Divider counter div counts 0..SCAN_DIV-1 and then wraps. On wrap, row index r advances 0→1→2→3→0.
- row_out = ~(4'b0001 << r).
- On the cycle where div == SCAN_DIV-1, ~col_sync is written into snapshot bits [4r+3:4r].
- When r == 3 is sampled, the full 16-bit snapshot is complete. This "scan end" event happens once every 4*SCAN_DIV cycles.
- Scan classes:
  - NONE: all snapshot bits 0.
  - SINGLE(k): exactly one bit k set.
  - MULTI: two or more bits set. MULTI is never reported.
- Per-scan match counter cnt:
  - Scan equal to the previous scan: cnt increments, saturating at DEBOUNCE_SCANS.
  - Scan different from the previous scan: cnt = 1.
- FSM, evaluated only at scan end:
  - IDLE → PRESS when class is SINGLE.
  - PRESS → HELD when cnt reaches DEBOUNCE_SCANS with class still SINGLE(k). In the same step: key_code ← k, key_valid pulse, key_held ← 1.
  - PRESS → IDLE when class is NONE or MULTI.
  - HELD → RELEASE when class is NONE. SINGLE or MULTI keep HELD; rollover to another key is not reported.
  - RELEASE → IDLE when cnt reaches DEBOUNCE_SCANS with class NONE. In the same step, key_held ← 0.
  - RELEASE → HELD when any key is seen before that.
- entry_value:
  - On key_valid: entry_value ← {entry_value[11:0], key_code}.
  - On entry_clear: entry_value ← 0.
  - If entry_clear and key_valid occur in the same cycle, clear wins and the digit is dropped. key_valid and key_code still update.
- Reset (in any state, including mid-scan): div=0, r=0, row_out=4'b1110, FSM=IDLE, cnt=0, previous snapshot=0, key_valid=0, key_code=0, key_held=0, entry_value=0.

## Timing
- Sample point is the last cycle of each row period. This leaves at least SCAN_DIV-1 cycles for row settling plus 2 cycles of synchronizer latency.
- key_valid is registered and goes high on the cycle after the scan-end cycle of the accepting scan. It lasts exactly one cycle.
- key_code and key_held change in that same cycle.
- entry_value updates in the same cycle key_valid is high.
- Minimum press latency, from stable contact to key_valid: DEBOUNCE_SCANS full scans, plus up to one partial scan, plus 3 cycles.
- Release latency: DEBOUNCE_SCANS full scans after the first all-NONE scan.
- key_valid fires at most once per press, however long the key is held.
- entry_clear takes effect on the next edge and is independent of scan phase.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3; keypad model: col c pulled low while row r is driven and key (r,c) is closed.
- **Reset:** assert Reset for 2 cycles with no key pressed → row_out=1110, entry_value=0000, key_valid never pulses; row_out then cycles 1110,1101,1011,0111 with 4 cycles per row.
- **Clean press/release:** hold key (2,1) for 20 scans → exactly one key_valid pulse, key_code=9, entry_value=0x0009, key_held=1; release → key_held falls 3 scans later.
- **Bounce:** toggle key (0,3) every scan for 6 scans, then hold steady → no pulse during bouncing; a single pulse with key_code=3 exactly 3 scans after it stabilizes.
- **Ghosting:** press keys (1,0) and (1,2) together → no key_valid. Release (1,2) only → after 3 stable scans, key_code=4 is accepted.
- **Entry sequence:** enter keys 1, A, 0, F, then 5 → entry_value steps 0001, 001A, 01A0, 1A0F, A0F5.
- **Clear collision and Reset mid-press:** assert entry_clear in the same cycle as key_valid → entry_value=0000 while key_code updates. Assert Reset while in PRESS → all outputs return to reset values and no pulse follows until a fresh 3-scan debounce completes.
